boid_frame_scheduler: RTL and testbench

//  Per-frame boid rasteriser feeding the 1-bit boid display RAM. The CPU writes boid

---
 rtl/boid_pkg.sv | 24 ++
 rtl/boid_sprite_addr.sv | 30 +++
 rtl/boid_frame_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_boid_frame_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boid_pkg.sv
// Shared constants and FSM encoding for the boid frame scheduler.
package boid_pkg;

  // Default display geometry
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_ADDR_W = $clog2(DEF_H_RES * DEF_V_RES);

  // Stored boid coordinate widths
  localparam int X_W = 10;
  localparam int Y_W = 9;

  // Coordinate sums carry one extra bit so off-screen pixels are never wrapped
  localparam int SX_W = X_W + 1;
  localparam int SY_W = Y_W + 1;

  // Scheduler phases
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

endpackage

// File: rtl/boid_sprite_addr.sv
// Combinational sprite pixel address generator: base position plus offset,
// clipped against the visible area, folded into a linear RAM address.
module boid_sprite_addr
  import boid_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = $clog2(H_RES * V_RES),
  parameter int D_W    = 1
) (
  input  logic [X_W-1:0]    base_x,
  input  logic [Y_W-1:0]    base_y,
  input  logic [D_W-1:0]    dx,
  input  logic [D_W-1:0]    dy,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);

  logic [SX_W-1:0] sum_x;
  logic [SY_W-1:0] sum_y;

  // Widened offset sums, range check and constant-multiply address
  always_comb begin
    sum_x    = {1'b0, base_x} + SX_W'(dx);
    sum_y    = {1'b0, base_y} + SY_W'(dy);
    in_range = (sum_x < SX_W'(H_RES)) && (sum_y < SY_W'(V_RES));
    addr     = ADDR_W'(sum_y) * ADDR_W'(H_RES) + ADDR_W'(sum_x);
  end

endmodule

// File: rtl/boid_frame_scheduler.sv
// Per-frame boid rasteriser. The CPU updates a shadow slot bank at any time;
// each frame_end snapshots it into a working bank, pulses buf_swap, and then
// sweeps every slot/pixel, emitting display RAM write addresses over a
// valid/ready port.
module boid_frame_scheduler
  import boid_pkg::*;
#(
  parameter int MAX_BOIDS = 32,
  parameter int SPRITE    = 2,
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int BOID_BITS = $clog2(MAX_BOIDS),
  parameter int ADDR_W    = $clog2(H_RES * V_RES)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 cpu_we,
  input  logic [BOID_BITS-1:0] cpu_slot,
  input  logic [X_W-1:0]       cpu_x,
  input  logic [Y_W-1:0]       cpu_y,
  input  logic                 cpu_active,
  input  logic                 frame_end,
  output logic                 buf_swap,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  // Offset counters need at least one bit even for single-pixel sprites
  localparam int D_W = (SPRITE > 1) ? $clog2(SPRITE) : 1;
  localparam logic [D_W-1:0]       D_LAST    = D_W'(SPRITE - 1);
  localparam logic [BOID_BITS-1:0] SLOT_LAST = BOID_BITS'(MAX_BOIDS - 1);

  // CPU-visible shadow bank
  logic [X_W-1:0] shadow_x      [MAX_BOIDS];
  logic [Y_W-1:0] shadow_y      [MAX_BOIDS];
  logic           shadow_active [MAX_BOIDS];

  // Frame snapshot that the sweep reads from
  logic [X_W-1:0] work_x      [MAX_BOIDS];
  logic [Y_W-1:0] work_y      [MAX_BOIDS];
  logic           work_active [MAX_BOIDS];

  state_t               state;
  logic [BOID_BITS-1:0] slot;
  logic [D_W-1:0]       dx;
  logic [D_W-1:0]       dy;

  logic [BOID_BITS-1:0] nxt_slot;
  logic [D_W-1:0]       nxt_dx;
  logic [D_W-1:0]       nxt_dy;
  logic                 last_pixel;
  logic                 advance;

  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic                 sel_active;
  logic [D_W-1:0]       sel_dx;
  logic [D_W-1:0]       sel_dy;
  logic                 pix_in_range;
  logic [ADDR_W-1:0]    pix_addr;

  // Shadow bank accepts CPU writes in every state; last write wins
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_BOIDS; i++) begin
        shadow_x[i]      <= '0;
        shadow_y[i]      <= '0;
        shadow_active[i] <= 1'b0;
      end
    end else if (cpu_we) begin
      shadow_x[cpu_slot]      <= cpu_x;
      shadow_y[cpu_slot]      <= cpu_y;
      shadow_active[cpu_slot] <= cpu_active;
    end
  end

  // Pixel walk order: dx fastest, then dy, then slot
  always_comb begin
    nxt_slot   = slot;
    nxt_dy     = dy;
    nxt_dx     = dx + D_W'(1);
    last_pixel = (slot == SLOT_LAST) && (dy == D_LAST) && (dx == D_LAST);
    if (dx == D_LAST) begin
      nxt_dx = '0;
      if (dy == D_LAST) begin
        nxt_dy   = '0;
        nxt_slot = slot + BOID_BITS'(1);
      end else begin
        nxt_dy = dy + D_W'(1);
      end
    end
  end

  // Current pixel leaves when it is either not offered or accepted
  assign advance = !wr_valid || wr_ready;

  // The first pixel is prepared during SWAP straight from the shadow bank,
  // because the working bank only receives its copy at the end of that cycle
  always_comb begin
    sel_x      = work_x[nxt_slot];
    sel_y      = work_y[nxt_slot];
    sel_active = work_active[nxt_slot];
    sel_dx     = nxt_dx;
    sel_dy     = nxt_dy;
    if (state == ST_SWAP) begin
      sel_x      = shadow_x[0];
      sel_y      = shadow_y[0];
      sel_active = shadow_active[0];
      sel_dx     = '0;
      sel_dy     = '0;
    end
  end

  boid_sprite_addr #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W),
    .D_W    (D_W)
  ) u_sprite_addr (
    .base_x   (sel_x),
    .base_y   (sel_y),
    .dx       (sel_dx),
    .dy       (sel_dy),
    .in_range (pix_in_range),
    .addr     (pix_addr)
  );

  // Frame FSM with registered swap pulse, busy flag and write port
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      slot     <= '0;
      dx       <= '0;
      dy       <= '0;
      buf_swap <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      for (int i = 0; i < MAX_BOIDS; i++) begin
        work_x[i]      <= '0;
        work_y[i]      <= '0;
        work_active[i] <= 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_end) begin
            state    <= ST_SWAP;
            buf_swap <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_SWAP: begin
          buf_swap <= 1'b0;
          for (int i = 0; i < MAX_BOIDS; i++) begin
            work_x[i]      <= shadow_x[i];
            work_y[i]      <= shadow_y[i];
            work_active[i] <= shadow_active[i];
          end
          slot     <= '0;
          dx       <= '0;
          dy       <= '0;
          wr_valid <= sel_active && pix_in_range;
          wr_addr  <= pix_addr;
          state    <= ST_SWEEP;
        end
        ST_SWEEP: begin
          if (advance) begin
            if (last_pixel) begin
              state    <= ST_IDLE;
              wr_valid <= 1'b0;
              busy     <= 1'b0;
            end else begin
              slot     <= nxt_slot;
              dx       <= nxt_dx;
              dy       <= nxt_dy;
              wr_valid <= sel_active && pix_in_range;
              wr_addr  <= pix_addr;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          buf_swap <= 1'b0;
          busy     <= 1'b0;
          wr_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new event outranks a simultaneous clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overrun <= 1'b0;
    end else if (frame_end && (state != ST_IDLE)) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Self-checking bench for boid_frame_scheduler (4 slots, 2x2 sprites).
module tb_boid_frame_scheduler;

  localparam int NB = 4;
  localparam int SP = 2;
  localparam int HR = 640;
  localparam int VR = 480;

  logic        clock = 1'b0;
  logic        resetn;
  logic        cpu_we;
  logic [1:0]  cpu_slot;
  logic [9:0]  cpu_x;
  logic [8:0]  cpu_y;
  logic        cpu_active;
  logic        frame_end;
  logic        buf_swap;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;

  int checks = 0;
  int errors = 0;

  // Reference model of the CPU-visible slot bank and the frame snapshot
  int m_x [NB];
  int m_y [NB];
  bit m_act [NB];
  int s_x [NB];
  int s_y [NB];
  bit s_act [NB];

  int expected[$];
  int observed[$];

  boid_frame_scheduler #(
    .MAX_BOIDS (NB),
    .SPRITE    (SP),
    .H_RES     (HR),
    .V_RES     (VR)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cpu_we      (cpu_we),
    .cpu_slot    (cpu_slot),
    .cpu_x       (cpu_x),
    .cpu_y       (cpu_y),
    .cpu_active  (cpu_active),
    .frame_end   (frame_end),
    .buf_swap    (buf_swap),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
      m_act[i] = 1'b0;
    end
  endtask

  task automatic cpu_write(input int slot, input int x, input int y, input bit act);
    @(negedge clock);
    cpu_we = 1'b1;
    cpu_slot = 2'(slot);
    cpu_x = 10'(x);
    cpu_y = 9'(y);
    cpu_active = act;
    @(negedge clock);
    cpu_we = 1'b0;
    m_x[slot] = x;
    m_y[slot] = y;
    m_act[slot] = act;
  endtask

  // Runs one frame: ready_mode 0 = always ready, 1 = random, 2 = stall first pixel 5 cycles.
  // Optional events at cycle index (frame_end pulse at cycle 0): extra frame_end,
  // overrun_clr, and a CPU write.
  task automatic run_frame(input int ready_mode, input int fe_at, input int clr_at,
                           input int wr_at, input int wr_slot, input int wr_x,
                           input int wr_y, input bit wr_act, input int exp_len);
    bit done;
    bit ready;
    bit prev_stall;
    bit first_emit;
    logic [18:0] prev_addr;
    int stall_left;
    expected.delete();
    observed.delete();
    for (int i = 0; i < NB; i++) begin
      s_x[i] = m_x[i];
      s_y[i] = m_y[i];
      s_act[i] = m_act[i];
    end
    for (int s = 0; s < NB; s++)
      for (int py = 0; py < SP; py++)
        for (int px = 0; px < SP; px++)
          if (s_act[s] && (s_x[s] + px < HR) && (s_y[s] + py < VR))
            expected.push_back((s_y[s] + py) * HR + s_x[s] + px);
    first_emit = s_act[0] && (s_x[0] < HR) && (s_y[0] < VR);
    @(negedge clock);
    frame_end = 1'b1;
    wr_ready = 1'b0;
    done = 1'b0;
    prev_stall = 1'b0;
    prev_addr = '0;
    stall_left = 5;
    for (int c = 1; c < 400 && !done; c++) begin
      @(negedge clock);
      frame_end = 1'b0;
      cpu_we = 1'b0;
      overrun_clr = 1'b0;
      if (c == 1) begin
        check("buf_swap_c1", buf_swap, 1);
        check("busy_c1", busy, 1);
        check("wr_valid_c1", wr_valid, 0);
      end
      if (c == 2) begin
        check("buf_swap_c2", buf_swap, 0);
        check("first_valid_c2", wr_valid, first_emit);
      end
      if (c == wr_at) begin
        cpu_we = 1'b1;
        cpu_slot = 2'(wr_slot);
        cpu_x = 10'(wr_x);
        cpu_y = 9'(wr_y);
        cpu_active = wr_act;
        m_x[wr_slot] = wr_x;
        m_y[wr_slot] = wr_y;
        m_act[wr_slot] = wr_act;
      end
      if (c == fe_at) frame_end = 1'b1;
      if (c == clr_at) overrun_clr = 1'b1;
      if (c >= 2) begin
        if (!busy) begin
          done = 1'b1;
          wr_ready = 1'b0;
          check("idle_valid", wr_valid, 0);
          if (exp_len >= 0) check("sweep_len", c - 2, exp_len);
        end else begin
          if (prev_stall) begin
            check("hold_valid", wr_valid, 1);
            check("hold_addr", wr_addr, prev_addr);
          end
          case (ready_mode)
            0: ready = 1'b1;
            1: ready = 1'($urandom_range(0, 1));
            default: begin
              if (wr_valid && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
              end else begin
                ready = 1'b1;
              end
            end
          endcase
          wr_ready = ready;
          if (wr_valid && ready) observed.push_back(int'(wr_addr));
          prev_stall = wr_valid && !ready;
          prev_addr = wr_addr;
        end
      end
    end
    cpu_we = 1'b0;
    frame_end = 1'b0;
    overrun_clr = 1'b0;
    check("frame_done", done, 1);
    check("addr_count", observed.size(), expected.size());
    for (int i = 0; i < expected.size(); i++)
      check("addr_seq", (i < observed.size()) ? observed[i] : -1, expected[i]);
  endtask

  initial begin
    resetn = 1'b0;
    cpu_we = 1'b0;
    cpu_slot = '0;
    cpu_x = '0;
    cpu_y = '0;
    cpu_active = 1'b0;
    frame_end = 1'b0;
    wr_ready = 1'b0;
    overrun_clr = 1'b0;
    model_reset();

    // Reset state
    #35;
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_buf_swap", buf_swap, 0);
    check("rst_overrun", overrun, 0);
    check("rst_wr_addr", wr_addr, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Empty bank: full-length sweep with nothing emitted
    run_frame(0, -1, -1, -1, 0, 0, 0, 1'b0, NB * SP * SP);

    // Single boid at (10,5), latency and minimum sweep length
    cpu_write(0, 10, 5, 1'b1);
    run_frame(0, -1, -1, -1, 0, 0, 0, 1'b0, NB * SP * SP);

    // Bottom-right corner: three pixels clipped, no wrap
    cpu_write(0, 639, 479, 1'b1);
    run_frame(0, -1, -1, -1, 0, 0, 0, 1'b0, NB * SP * SP);

    // Backpressure on the first pixel of slot 1 at the origin
    cpu_write(0, 0, 0, 1'b0);
    cpu_write(1, 0, 0, 1'b1);
    run_frame(2, -1, -1, -1, 0, 0, 0, 1'b0, -1);

    // Overrun during sweep, sequence unaffected, then clear
    cpu_write(2, 100, 200, 1'b1);
    run_frame(0, 6, -1, -1, 0, 0, 0, 1'b0, NB * SP * SP);
    check("overrun_set", overrun, 1);
    @(negedge clock);
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 0);

    // New overrun event together with a clear leaves overrun set
    run_frame(1, 7, 7, -1, 0, 0, 0, 1'b0, -1);
    check("overrun_set_wins", overrun, 1);
    @(negedge clock);
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    check("overrun_cleared2", overrun, 0);

    // CPU write mid-sweep lands next frame
    cpu_write(1, 0, 0, 1'b0);
    cpu_write(2, 0, 0, 1'b0);
    cpu_write(0, 10, 5, 1'b1);
    run_frame(0, -1, -1, 5, 0, 20, 5, 1'b1, NB * SP * SP);
    // Write coinciding with the SWAP cycle also lands next frame
    run_frame(0, -1, -1, 1, 0, 30, 5, 1'b1, NB * SP * SP);
    run_frame(0, -1, -1, -1, 0, 0, 0, 1'b0, NB * SP * SP);

    // Randomised slot contents biased towards the clipping edges, random backpressure
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < NB; s++) begin
        cpu_write(s,
                  ($urandom_range(0, 2) == 0) ? 638 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 639)),
                  ($urandom_range(0, 2) == 0) ? 478 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 479)),
                  1'($urandom_range(0, 3) != 0));
      end
      if (f == 3) cpu_write(1, m_x[0], m_y[0], 1'b1);
      run_frame(1, -1, -1, -1, 0, 0, 0, 1'b0, -1);
    end

    // Asynchronous reset mid-sweep with a pending write
    cpu_write(0, 100, 100, 1'b1);
    @(negedge clock);
    frame_end = 1'b1;
    wr_ready = 1'b0;
    @(negedge clock);
    frame_end = 1'b0;
    for (int k = 0; k < 10 && !wr_valid; k++) @(negedge clock);
    check("t6_pending", wr_valid, 1);
    #3;
    resetn = 1'b0;
    #1;
    check("t6_wr_valid", wr_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_buf_swap", buf_swap, 0);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    run_frame(0, -1, -1, -1, 0, 0, 0, 1'b0, NB * SP * SP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
